// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage: PC, credit-limited imem requests, in-order instruction FIFO
module ifetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] fetch_pc, resp_pc, target;
    logic [CW-1:0]   occupancy, outstanding, discard;
    logic [CW-1:0]   outstanding_nxt, discard_nxt;
    logic [CW:0]     used;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [31:0]     mem_data [DEPTH];
    logic [XLEN-1:0] mem_pc [DEPTH];
    logic            hold, credit, redir, grant, rsp, drop, push, pop, pop_req;

    assign target  = redirect_pc & ~XLEN'(3);
    assign redir   = redirect && (state != IDLE);
    assign pop_req = inst_valid && inst_ready;
    assign pop     = pop_req && !redir;
    assign grant   = imem_req && imem_gnt;
    // rvalid with nothing outstanding is a protocol error and is ignored
    assign rsp     = imem_rvalid && (outstanding != '0);
    assign drop    = rsp && (discard != '0);
    assign push    = rsp && !drop && !redir;

    // A slot popped this cycle counts as free; a held request keeps req/addr stable until granted
    assign used     = {1'b0, occupancy} + {1'b0, outstanding};
    assign credit   = used < (DEPTH_C + (CW+1)'(pop_req));
    assign imem_req = (state == FETCH) && (hold || credit);
    assign imem_addr = fetch_pc;

    assign outstanding_nxt = outstanding + CW'(grant) - CW'(rsp);
    assign discard_nxt     = redir ? outstanding_nxt : discard - CW'(drop);

    assign inst_valid = occupancy != '0;
    assign inst       = mem_data[rd_ptr];
    assign inst_pc    = mem_pc[rd_ptr];
    assign opcode     = inst[6:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH,
            FLUSH: begin
                if (redir)
                    state_nxt = (outstanding_nxt != '0) ? FLUSH : FETCH;
                else if ((state == FLUSH) && (discard_nxt == '0))
                    state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            occupancy   <= '0;
            outstanding <= '0;
            discard     <= '0;
            hold        <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
            hold        <= imem_req && !imem_gnt && !redir;
            if (redir) begin
                fetch_pc  <= target;
                resp_pc   <= target;
                occupancy <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
            end else begin
                if (grant)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (push) begin
                    mem_data[wr_ptr] <= imem_rdata;
                    mem_pc[wr_ptr]   <= resp_pc;
                    wr_ptr           <= wr_ptr + PW'(1);
                    resp_pc          <= resp_pc + XLEN'(4);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                occupancy <= occupancy + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - randomized self-checking bench for ifetch against a stream-level reference model
module tb_ifetch;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect, inst_valid, inst_ready;
    logic [31:0] redirect_pc, inst, inst_pc;
    logic [6:0]  opcode;

    always #5 clk = ~clk;

    ifetch #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .opcode(opcode)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } rsp_t;

    int          n_cmp = 0, n_err = 0;
    int          cyc, last_due, pops;
    int          gnt_pct, ready_pct, lat_min, lat_max;
    rsp_t        mq[$];
    logic [31:0] m_fetch, m_exp, redir_tgt, obs_pc;
    int          m_stale, m_buf;
    logic        redir_now, prev_hold, prev_redir;
    logic        obs_valid, obs_req, obs_gnt, obs_pop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a | 32'h13;
    endfunction

    task automatic model_reset();
        mq.delete();
        last_due = 0; pops = 0;
        m_fetch = RESET_PC; m_exp = RESET_PC;
        m_stale = 0; m_buf = 0;
        prev_hold = 1'b0; prev_redir = 1'b0; redir_now = 1'b0;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 1;
        #1;
    endtask

    // One clock cycle: drive memory/consumer, check DUT against model, then advance model
    task automatic step();
        logic        g, p, r, rv;
        logic [31:0] want;
        int          lat, due;
        rsp_t        e;
        @(negedge clk);
        cyc++;
        rv = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        if (mq.size() > 0) begin
            e = mq[0];
            if (e.due == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem_word(e.addr);
                void'(mq.pop_front());
                rv = 1'b1;
            end
        end
        imem_gnt   = int'($urandom_range(99)) < gnt_pct;
        inst_ready = int'($urandom_range(99)) < ready_pct;
        r = redir_now;
        redirect = r;
        redirect_pc = r ? redir_tgt : $urandom;
        redir_now = 1'b0;
        #1;
        g = imem_req && imem_gnt;
        p = inst_valid && inst_ready && !r;

        n_cmp++;
        if (inst_valid !== (m_buf != 0)) begin
            n_err++; $display("FAIL inst_valid c%0d: got %0b want %0b", cyc, inst_valid, m_buf != 0);
        end
        if (prev_redir) begin
            n_cmp++;
            if (inst_valid !== 1'b0) begin
                n_err++; $display("FAIL valid_after_redirect c%0d: got %0b want 0", cyc, inst_valid);
            end
        end
        if (m_stale > 0) begin
            n_cmp++;
            if (imem_req !== 1'b0) begin
                n_err++; $display("FAIL req_in_flush c%0d: got %0b want 0 (stale %0d)", cyc, imem_req, m_stale);
            end
        end
        if (prev_hold) begin
            n_cmp++;
            if (imem_req !== 1'b1) begin
                n_err++; $display("FAIL req_dropped_ungranted c%0d: got %0b want 1", cyc, imem_req);
            end
        end
        if (imem_req) begin
            n_cmp++;
            if (imem_addr !== m_fetch) begin
                n_err++; $display("FAIL imem_addr c%0d: got %h want %h", cyc, imem_addr, m_fetch);
            end
        end
        if (p) begin
            want = mem_word(m_exp);
            n_cmp++;
            if (inst_pc !== m_exp || inst !== want || opcode !== want[6:0]) begin
                n_err++;
                $display("FAIL pop c%0d: got pc %h inst %h op %h want pc %h inst %h op %h",
                         cyc, inst_pc, inst, opcode, m_exp, want, want[6:0]);
            end
        end

        if (rv) begin
            if (m_stale > 0) m_stale--;
            else m_buf++;
        end
        if (p) begin
            m_buf--; m_exp += 4; pops++;
        end
        if (g) begin
            lat = int'($urandom_range(lat_max, lat_min));
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            e.due = due; e.addr = m_fetch;
            mq.push_back(e);
            last_due = due;
            m_fetch += 4;
        end
        if (r) begin
            m_fetch = redir_tgt & ~32'h3;
            m_exp = m_fetch;
            m_buf = 0;
            m_stale = mq.size();
        end
        n_cmp++;
        if (m_buf + mq.size() > DEPTH) begin
            n_err++; $display("FAIL credit c%0d: buffered+inflight %0d want <= %0d", cyc, m_buf + mq.size(), DEPTH);
        end
        prev_hold = imem_req && !imem_gnt && !r;
        prev_redir = r;
        obs_valid = inst_valid; obs_req = imem_req; obs_gnt = imem_gnt;
        obs_pop = p; obs_pc = inst_pc;
    endtask

    task automatic wait_first_pop(input string name, input logic [31:0] want_pc);
        int n;
        n = 0;
        obs_pop = 1'b0;
        while (!obs_pop && n < 20) begin
            step(); n++;
        end
        n_cmp++;
        if (!obs_pop || obs_pc !== want_pc) begin
            n_err++; $display("FAIL %s: popped %0b pc %h want pop pc %h", name, obs_pop, obs_pc, want_pc);
        end
    endtask

    task automatic test_reset();
        assert_reset();
        n_cmp++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || inst_valid !== 1'b0 ||
            inst !== 32'h0 || inst_pc !== 32'h0 || opcode !== 7'h0) begin
            n_err++;
            $display("FAIL reset_values: req %0b addr %h valid %0b inst %h pc %h op %h want 0 %h 0 0 0 0",
                     imem_req, imem_addr, inst_valid, inst, inst_pc, opcode, RESET_PC);
        end
        release_reset();
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_err++; $display("FAIL req_cycle1: got %0b want 0", imem_req);
        end
        gnt_pct = 0; ready_pct = 0; lat_min = 1; lat_max = 1;
        step();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            n_err++; $display("FAIL req_cycle2: got req %0b addr %h want 1 %h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_streaming();
        int first_valid;
        assert_reset();
        release_reset();
        gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
        first_valid = -1;
        while (cyc < 24) begin
            step();
            if (first_valid < 0 && obs_valid) first_valid = cyc;
        end
        n_cmp++;
        if (first_valid != 4) begin
            n_err++; $display("FAIL stream_first_valid: got cycle %0d want 4", first_valid);
        end
        n_cmp++;
        if (pops != 21) begin
            n_err++; $display("FAIL stream_throughput: got %0d pops want 21", pops);
        end
    endtask

    task automatic test_backpressure();
        ready_pct = 0;
        repeat (10) step();
        n_cmp++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b1 || imem_addr !== m_fetch) begin
            n_err++;
            $display("FAIL backpressure_hold: req %0b valid %0b addr %h want 0 1 %h", imem_req, inst_valid, imem_addr, m_fetch);
        end
        pops = 0;
        ready_pct = 100;
        repeat (10) step();
        n_cmp++;
        if (pops < 8) begin
            n_err++; $display("FAIL backpressure_resume: got %0d pops want >= 8", pops);
        end
    endtask

    task automatic test_gnt_stall();
        assert_reset();
        release_reset();
        gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
        step();
        step();
        gnt_pct = 0;
        repeat (3) begin
            step();
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
                n_err++; $display("FAIL gnt_stall_hold c%0d: req %0b addr %h want 1 00000008", cyc, imem_req, imem_addr);
            end
        end
        gnt_pct = 100;
        step();
        step();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            n_err++; $display("FAIL gnt_stall_advance: req %0b addr %h want 1 0000000c", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_inflight();
        assert_reset();
        release_reset();
        gnt_pct = 100; ready_pct = 0; lat_min = 3; lat_max = 3;
        step();
        step();
        redir_now = 1'b1; redir_tgt = 32'h100; ready_pct = 100;
        step();
        repeat (2) begin
            step();
            n_cmp++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                n_err++; $display("FAIL inflight_flush c%0d: req %0b valid %0b want 0 0", cyc, imem_req, inst_valid);
            end
        end
        step();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_err++; $display("FAIL inflight_refetch: req %0b addr %h want 1 00000100", imem_req, imem_addr);
        end
        wait_first_pop("inflight_first_pc", 32'h100);
    endtask

    task automatic test_redirect_edge();
        assert_reset();
        release_reset();
        gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
        while (cyc < 10) step();
        redir_now = 1'b1; redir_tgt = 32'h203;
        step();
        n_cmp++;
        if (!(obs_req && obs_gnt && obs_valid)) begin
            n_err++; $display("FAIL edge_setup: req %0b gnt %0b valid %0b want 1 1 1", obs_req, obs_gnt, obs_valid);
        end
        step();
        n_cmp++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_err++; $display("FAIL edge_after: valid %0b req %0b want 0 0", inst_valid, imem_req);
        end
        wait_first_pop("edge_first_pc", 32'h200);
    endtask

    task automatic test_async_reset();
        assert_reset();
        release_reset();
        gnt_pct = 100; ready_pct = 0; lat_min = 4; lat_max = 4;
        step();
        step();
        redir_now = 1'b1; redir_tgt = 32'h300;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || inst_valid !== 1'b0 ||
            inst !== 32'h0 || inst_pc !== 32'h0 || opcode !== 7'h0) begin
            n_err++;
            $display("FAIL async_reset_values: req %0b addr %h valid %0b inst %h pc %h op %h",
                     imem_req, imem_addr, inst_valid, inst, inst_pc, opcode);
        end
        rst_n = 1'b1;
        imem_rvalid = 1'b0;
        model_reset();
        ready_pct = 100; lat_min = 1; lat_max = 2;
        step();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            n_err++; $display("FAIL async_restart: req %0b addr %h want 1 %h", imem_req, imem_addr, RESET_PC);
        end
        wait_first_pop("async_first_pc", RESET_PC);
    endtask

    task automatic test_random();
        assert_reset();
        release_reset();
        pops = 0;
        for (int ph = 0; ph < 3; ph++) begin
            gnt_pct = 50 + 20 * ph; ready_pct = 90 - 25 * ph;
            lat_min = 1; lat_max = 1 + ph * 2;
            for (int i = 0; i < 800; i++) begin
                if (i == 40) begin
                    redir_now = 1'b1; redir_tgt = 32'hFFFF_FFF0;
                end else if (int'($urandom_range(99)) < 4) begin
                    redir_now = 1'b1; redir_tgt = $urandom;
                end
                step();
            end
        end
        gnt_pct = 100; ready_pct = 100;
        repeat (30) step();
        n_cmp++;
        if (pops < 300) begin
            n_err++; $display("FAIL random_progress: got %0d pops want >= 300", pops);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        cyc = 0;
        gnt_pct = 0; ready_pct = 0; lat_min = 1; lat_max = 1;
        obs_valid = 1'b0; obs_req = 1'b0; obs_gnt = 1'b0; obs_pop = 1'b0; obs_pc = '0;
        model_reset();
        test_reset();
        test_streaming();
        test_backpressure();
        test_gnt_stall();
        test_redirect_inflight();
        test_redirect_edge();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
